// File: rtl/vga_image_writer_pkg.sv
// Shared definitions for the VGA image RAM write bus: field layout, writer FSM states,
// and the image_word pack helper used by both producer and consumer.
package vga_pkg;

  localparam int WEN_BIT   = 23;
  localparam int COLOR_LSB = 15;
  localparam int COLOR_W   = 8;
  localparam int ADDR_W    = 15;
  localparam int X_W       = 11;
  localparam int BAND_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SETUP,
    WRITE,
    RELEASE
  } state_t;

  // Address is {1'b0, band, x}; bits above WEN_BIT are always zero.
  function automatic logic [31:0] pack_word(input logic               wen,
                                            input logic [COLOR_W-1:0] color,
                                            input logic [BAND_W-1:0]  band,
                                            input logic [X_W-1:0]     x);
    logic [31:0] w;
    w                         = '0;
    w[WEN_BIT]                = wen;
    w[COLOR_LSB +: COLOR_W]   = color;
    w[ADDR_W-1:0]             = {1'b0, band, x};
    return w;
  endfunction

endpackage

// File: rtl/vga_image_writer_if.sv
// Command handshake plus image_word/status bundle between the CPU IO decode and the writer.
interface vga_image_writer_if;
  import vga_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [X_W-1:0]      cmd_x0;
  logic [X_W-1:0]      cmd_x1;
  logic [BAND_W-1:0]   cmd_b0;
  logic [BAND_W-1:0]   cmd_b1;
  logic [COLOR_W-1:0]  cmd_color;
  logic [31:0]         image_word;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output cmd_valid, cmd_x0, cmd_x1, cmd_b0, cmd_b1, cmd_color,
    input  cmd_ready, image_word, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_b0, cmd_b1, cmd_color,
    output cmd_ready, image_word, busy, done, err
  );

endinterface

// File: rtl/vga_image_writer_stepper.sv
// Rectangle scan position: x inner loop, band outer loop, with a wrap-free last-pixel flag.
module vga_rect_stepper
  import vga_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [X_W-1:0]    x0,
  input  logic [X_W-1:0]    x1,
  input  logic [BAND_W-1:0] b0,
  input  logic [BAND_W-1:0] b1,
  output logic [X_W-1:0]    cur_x,
  output logic [BAND_W-1:0] cur_b,
  output logic              last_pixel
);

  logic [X_W:0]    x_next;
  logic [BAND_W:0] b_next;
  logic            x_wrap;
  logic            b_wrap;

  // One extra bit so x1=2047 / b1=7 compare correctly instead of wrapping to zero.
  assign x_next     = {1'b0, cur_x} + (X_W+1)'(1);
  assign b_next     = {1'b0, cur_b} + (BAND_W+1)'(1);
  assign x_wrap     = x_next > {1'b0, x1};
  assign b_wrap     = b_next > {1'b0, b1};
  assign last_pixel = x_wrap && b_wrap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_x <= '0;
      cur_b <= '0;
    end else if (load) begin
      cur_x <= x0;
      cur_b <= b0;
    end else if (step) begin
      if (x_wrap) begin
        cur_x <= x0;
        cur_b <= b_next[BAND_W-1:0];
      end else begin
        cur_x <= x_next[X_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vga_image_writer.sv
// Rectangle-fill writer: per pixel, address/color settle, wEn pulses, then fields hold
// before changing, so the VGA domain can sample the word without synchronisers.
module vga_image_writer
  import vga_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 4
) (
  input logic              clock,
  input logic              reset,
  vga_image_writer_if.slave bus
);

  localparam int MAX_CYC = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 wen, wen_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 capture, load, step;
  logic [X_W-1:0]       x0_q, x1_q;
  logic [BAND_W-1:0]    b0_q, b1_q;
  logic [COLOR_W-1:0]   color_q, color_out;
  logic [X_W-1:0]       cur_x;
  logic [BAND_W-1:0]    cur_b;
  logic                 last_pixel;

  vga_rect_stepper u_stepper (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .x0         (x0_q),
    .x1         (x1_q),
    .b0         (b0_q),
    .b1         (b1_q),
    .cur_x      (cur_x),
    .cur_b      (cur_b),
    .last_pixel (last_pixel)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wen_d   = wen;
    done_d  = 1'b0;
    err_d   = 1'b0;
    capture = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          capture = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((x1_q < x0_q) || (b1_q < b0_q)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          load    = 1'b1;
          cnt_d   = SETUP_LOAD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          wen_d   = 1'b1;
          cnt_d   = HOLD_LOAD;
          state_d = WRITE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      WRITE: begin
        if (cnt == '0) begin
          wen_d   = 1'b0;
          cnt_d   = SETUP_LOAD;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt == '0) begin
          if (last_pixel) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            step    = 1'b1;
            cnt_d   = SETUP_LOAD;
            state_d = SETUP;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wen       <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      x0_q      <= '0;
      x1_q      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      color_q   <= '0;
      color_out <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      wen    <= wen_d;
      done_q <= done_d;
      err_q  <= err_d;
      if (capture) begin
        x0_q    <= bus.cmd_x0;
        x1_q    <= bus.cmd_x1;
        b0_q    <= bus.cmd_b0;
        b1_q    <= bus.cmd_b1;
        color_q <= bus.cmd_color;
      end
      // Displayed color moves together with the first address, never at capture.
      if (load) color_out <= color_q;
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.image_word = pack_word(wen, color_out, cur_b, cur_x);

endmodule

// File: tb/tb_vga_image_writer.sv
// Scoreboard bench for vga_image_writer: stimulus queues expected writes/done/err with
// their cycle numbers; a forked monitor pops and compares as the DUT produces them.
module tb_vga_image_writer;
  import vga_pkg::*;

  localparam int S = 2;
  localparam int H = 4;
  localparam int P = 2 * S + H;

  typedef enum int {EV_WRITE, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] word;
    int          at;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  vga_image_writer_if bus ();

  vga_image_writer #(.SETUP_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] exp_word(input bit wen, input logic [7:0] c,
                                           input logic [2:0] b, input logic [10:0] x);
    return {8'h00, wen, c, 1'b0, b, x};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_event(input ev_kind_t k, input logic [31:0] w);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s word 0x%08h at cycle %0d, required no event",
               k.name(), w, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      if (k == EV_WRITE) chk("write_word", w, e.word);
      chk("event_cycle", 32'(cyc), 32'(e.at));
    end
  endtask

  task automatic monitor();
    logic [31:0] prev, w;
    int zero_run, same_run, hi_run;
    prev = '0; zero_run = 100; same_run = 100; hi_run = 0;
    forever begin
      @(negedge clock);
      w = bus.image_word;
      if (reset) begin
        prev = w; zero_run = 100; same_run = 100; hi_run = 0;
        continue;
      end
      if (w[22:0] != prev[22:0]) begin
        chk("change_while_wen", {31'b0, w[23] | prev[23]}, 32'd0);
        chk("change_gap_after_wen", {31'b0, zero_run >= S}, 32'd1);
      end
      if (w[23] && !prev[23]) begin
        chk("wen_rise_setup", {31'b0, same_run >= S}, 32'd1);
        expect_event(EV_WRITE, w);
      end
      if (!w[23] && prev[23]) chk("wen_width", 32'(hi_run), 32'(H));
      if (bus.done) expect_event(EV_DONE, 32'd0);
      if (bus.err)  expect_event(EV_ERR, 32'd0);
      if (w[22:0] != prev[22:0]) same_run = w[23] ? 0 : 1;
      else if (!w[23]) same_run++;
      else same_run = 0;
      hi_run   = w[23] ? hi_run + 1 : 0;
      zero_run = w[23] ? 0 : zero_run + 1;
      prev = w;
    end
  endtask

  task automatic issue(input logic [10:0] x0, input logic [10:0] x1,
                       input logic [2:0] b0, input logic [2:0] b1,
                       input logic [7:0] c, output int e0);
    int n, k;
    ev_t e;
    @(negedge clock);
    bus.cmd_x0 = x0; bus.cmd_x1 = x1; bus.cmd_b0 = b0; bus.cmd_b1 = b1;
    bus.cmd_color = c; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      e0 = -1;
      return;
    end
    e0 = cyc + 1;
    if (x1 < x0 || b1 < b0) begin
      e.kind = EV_ERR; e.word = '0; e.at = e0 + 1;
      exp_q.push_back(e);
    end else begin
      k = 0;
      for (int b = int'(b0); b <= int'(b1); b++) begin
        for (int x = int'(x0); x <= int'(x1); x++) begin
          e.kind = EV_WRITE; e.word = exp_word(1'b1, c, 3'(b), 11'(x));
          e.at = e0 + 1 + S + k * P;
          exp_q.push_back(e);
          k++;
        end
      end
      e.kind = EV_DONE; e.word = '0; e.at = e0 + 1 + k * P;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic at_cycle(input int t);
    int g;
    g = 0;
    while (cyc < t && g < 1000) begin
      @(negedge clock);
      g++;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 3000) begin
      @(negedge clock);
      g++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    int e0, e0b;
    bus.cmd_valid = 1'b0; bus.cmd_x0 = '0; bus.cmd_x1 = '0;
    bus.cmd_b0 = '0; bus.cmd_b1 = '0; bus.cmd_color = '0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clock);
    chk("reset_word",  bus.image_word, 32'h0);
    chk("reset_busy",  {31'b0, bus.busy}, 32'd0);
    chk("reset_done",  {31'b0, bus.done}, 32'd0);
    chk("reset_err",   {31'b0, bus.err}, 32'd0);
    chk("reset_ready", {31'b0, bus.cmd_ready}, 32'd1);
    #1 reset = 1'b0;

    // Single pixel at x 5, band 2, color 0x3C.
    issue(11'd5, 11'd5, 3'd2, 3'd2, 8'h3C, e0);
    at_cycle(e0 + 1);
    chk("pixel_setup_word", bus.image_word, 32'h001E1005);
    at_cycle(e0 + 3);
    chk("pixel_write_word", bus.image_word, 32'h009E1005);
    wait_idle();
    chk("pixel_idle_word", bus.image_word, 32'h001E1005);
    chk("pixel_idle_ready", {31'b0, bus.cmd_ready}, 32'd1);

    // 3x2 rectangle.
    issue(11'd10, 11'd12, 3'd0, 3'd1, 8'h00, e0);
    wait_idle();

    // Rejected commands: x reversed, then band reversed.
    issue(11'd7, 11'd6, 3'd3, 3'd3, 8'h55, e0);
    at_cycle(e0 + 1);
    chk("err_pulse",   {31'b0, bus.err}, 32'd1);
    chk("err_ready",   {31'b0, bus.cmd_ready}, 32'd1);
    chk("err_no_wen",  {31'b0, bus.image_word[23]}, 32'd0);
    wait_idle();
    issue(11'd0, 11'd0, 3'd5, 3'd4, 8'h66, e0);
    wait_idle();

    // Top-right corner: must stop at 2047 without touching x=0.
    issue(11'd2046, 11'd2047, 3'd7, 3'd7, 8'h81, e0);
    wait_idle();
    chk("corner_idle_word", bus.image_word, 32'h0040BFFF);

    // Reset in the second WRITE cycle.
    issue(11'd0, 11'd3, 3'd0, 3'd0, 8'h11, e0);
    at_cycle(e0 + 1 + S + 1);
    #1 reset = 1'b1;
    #1;
    chk("midreset_word",  bus.image_word, 32'h0);
    chk("midreset_busy",  {31'b0, bus.busy}, 32'd0);
    chk("midreset_ready", {31'b0, bus.cmd_ready}, 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    repeat (12) @(negedge clock);
    issue(11'd100, 11'd100, 3'd3, 3'd3, 8'hFF, e0);
    wait_idle();

    // Valid held with changing fields while busy; next command lands on the done cycle.
    issue(11'd20, 11'd21, 3'd1, 3'd1, 8'h0F, e0);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_x0 = 11'(i * 3); bus.cmd_x1 = 11'(i * 7 + 1);
      bus.cmd_b0 = 3'(i); bus.cmd_b1 = 3'd7; bus.cmd_color = 8'(i + 8'hE0);
      @(negedge clock);
      chk("busy_not_ready", {31'b0, bus.cmd_ready}, 32'd0);
    end
    issue(11'd30, 11'd30, 3'd4, 3'd4, 8'hA5, e0b);
    chk("b2b_accept_cycle", 32'(e0b), 32'(e0 + 1 + 2 * P + 1));
    wait_idle();

    repeat (20) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
